// File: rtl/uart_frame_decoder_pkg.sv
// Shared constants, state encoding and sizing helper for the UART frame decoder.
package uart_frame_decoder_pkg;

  // Display codes driven onto every digit after reset and after a bad byte.
  localparam logic [3:0] BLANK_CODE = 4'b1011;
  localparam logic [3:0] ERR_CODE   = 4'b1010;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_e;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/uart_frame_decoder_frame_timer.sv
// Inter-byte idle timer: clears on load, counts up while enabled,
// saturates at TIMEOUT_CYC and flags expiry while parked there.
module uart_frame_decoder_frame_timer #(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic count_i,
  output logic expired_o
);
  import uart_frame_decoder_pkg::*;

  localparam int unsigned   TW    = cnt_width(TIMEOUT_CYC + 32'd1);
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYC);

  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;

  // Next timer value: clear on load, increment until the limit, otherwise hold.
  always_comb begin
    timer_d = timer_q;
    if (load_i) begin
      timer_d = '0;
    end else if (count_i && (timer_q != LIMIT)) begin
      timer_d = timer_q + TW'(1);
    end else begin
      timer_d = timer_q;
    end
  end

  // Timer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  // A zero limit disables the timeout entirely.
  assign expired_o = (TIMEOUT_CYC != 32'd0) && (timer_q == LIMIT);

endmodule

// File: rtl/uart_frame_decoder.sv
// Collects UART bytes into a frame, optionally bit-reverses it and presents it
// as display digits; flags good, errored and timed-out frames with 1-cycle pulses.
module uart_frame_decoder #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned DIGIT_W     = 4,
  parameter int unsigned BYTE_W      = 8,
  parameter int unsigned BIT_REVERSE = 1,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [BYTE_W-1:0]             Rx_DATA,
  input  logic                          Rx_VALID,
  input  logic                          Rx_FERROR,
  input  logic                          Rx_PERROR,
  output logic [NUM_DIGITS*DIGIT_W-1:0] digits,
  output logic                          frame_valid,
  output logic                          frame_error,
  output logic                          frame_timeout
);
  import uart_frame_decoder_pkg::*;

  localparam int unsigned FRAME_W = NUM_DIGITS * DIGIT_W;
  localparam int unsigned BPF     = FRAME_W / BYTE_W;
  localparam int unsigned CW      = cnt_width(BPF);
  localparam logic [CW-1:0]      LAST_IDX   = CW'(BPF - 32'd1);
  localparam logic [FRAME_W-1:0] BLANK_WORD = {NUM_DIGITS{DIGIT_W'(BLANK_CODE)}};
  localparam logic [FRAME_W-1:0] ERR_WORD   = {NUM_DIGITS{DIGIT_W'(ERR_CODE)}};

  state_e               state_q, state_d;
  logic [CW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic [FRAME_W-1:0]   digits_q, digits_d;
  logic                 valid_q, valid_d;
  logic                 error_q, error_d;
  logic                 timeout_q, timeout_d;
  logic                 timer_load_s, timer_count_s, timer_expired_s;
  logic                 good_byte_s, bad_byte_s, last_byte_s;
  logic [FRAME_W-1:0]   assembled_s, frame_s;

  assign good_byte_s = Rx_VALID && !Rx_FERROR && !Rx_PERROR;
  assign bad_byte_s  = Rx_VALID && (Rx_FERROR || Rx_PERROR);
  // byte_cnt is 0 in IDLE, so with a single-byte frame every byte is the last.
  assign last_byte_s = (byte_cnt_q == LAST_IDX);
  // Earlier bytes move toward the MSBs; the incoming byte lands in the LSBs.
  assign assembled_s = FRAME_W'({shift_q, Rx_DATA});

  // Optional bit reversal of the assembled word and split into digit lanes.
  for (genvar i = 0; i < FRAME_W; i++) begin : g_bit
    if (BIT_REVERSE != 32'd0) begin : g_rev
      assign frame_s[i] = assembled_s[FRAME_W-1-i];
    end else begin : g_pass
      assign frame_s[i] = assembled_s[i];
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    assign digits[k*DIGIT_W +: DIGIT_W] = digits_q[k*DIGIT_W +: DIGIT_W];
  end

  uart_frame_decoder_frame_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_frame_timer (
    .clk       (clk),
    .rst_n     (reset),
    .load_i    (timer_load_s),
    .count_i   (timer_count_s),
    .expired_o (timer_expired_s)
  );

  // Next-state logic: errors beat commits, a byte beats an expiring timer.
  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    shift_d       = shift_q;
    digits_d      = digits_q;
    valid_d       = 1'b0;
    error_d       = 1'b0;
    timeout_d     = 1'b0;
    timer_load_s  = 1'b0;
    timer_count_s = 1'b0;
    if (bad_byte_s) begin
      state_d      = ST_IDLE;
      byte_cnt_d   = '0;
      shift_d      = '1;
      digits_d     = ERR_WORD;
      error_d      = 1'b1;
      timer_load_s = 1'b1;
    end else if (good_byte_s) begin
      timer_load_s = 1'b1;
      if (last_byte_s) begin
        state_d    = ST_IDLE;
        byte_cnt_d = '0;
        shift_d    = '1;
        digits_d   = frame_s;
        valid_d    = 1'b1;
      end else begin
        state_d    = ST_COLLECT;
        byte_cnt_d = byte_cnt_q + CW'(1);
        shift_d    = assembled_s;
      end
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (timer_expired_s) begin
            state_d      = ST_IDLE;
            byte_cnt_d   = '0;
            shift_d      = '1;
            timeout_d    = 1'b1;
            timer_load_s = 1'b1;
          end else begin
            timer_count_s = 1'b1;
          end
        end
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d    = ST_IDLE;
          byte_cnt_d = '0;
          shift_d    = '1;
        end
      endcase
    end
  end

  // State, assembly buffer, displayed digits and status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      shift_q    <= '1;
      digits_q   <= BLANK_WORD;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      digits_q   <= digits_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      timeout_q  <= timeout_d;
    end
  end

  assign frame_valid   = valid_q;
  assign frame_error   = error_q;
  assign frame_timeout = timeout_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Scoreboard bench: three decoder configurations share one Rx stimulus bus;
// each test selects the instance whose pulses the monitor scores.
module tb_uart_frame_decoder;

  localparam logic [1:0] K_VALID   = 2'd0;
  localparam logic [1:0] K_ERROR   = 2'd1;
  localparam logic [1:0] K_TIMEOUT = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [23:0] dig;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ferror, rx_perror;
  logic [15:0] dig_a, dig_b;
  logic [23:0] dig_c;
  logic        fv_a, fe_a, ft_a, fv_b, fe_b, ft_b, fv_c, fe_c, ft_c;

  exp_t exp_q[$];
  int   sel;
  int   total;
  int   bad;

  always #5 clk = ~clk;

  // A: reversing, 4 digits, short timeout.
  uart_frame_decoder #(.NUM_DIGITS(4), .DIGIT_W(4), .BYTE_W(8), .BIT_REVERSE(1), .TIMEOUT_CYC(8)) dut_a (
    .clk(clk), .reset(reset), .Rx_DATA(rx_data), .Rx_VALID(rx_valid), .Rx_FERROR(rx_ferror),
    .Rx_PERROR(rx_perror), .digits(dig_a), .frame_valid(fv_a), .frame_error(fe_a), .frame_timeout(ft_a));

  // B: pass-through, timeout disabled.
  uart_frame_decoder #(.NUM_DIGITS(4), .DIGIT_W(4), .BYTE_W(8), .BIT_REVERSE(0), .TIMEOUT_CYC(0)) dut_b (
    .clk(clk), .reset(reset), .Rx_DATA(rx_data), .Rx_VALID(rx_valid), .Rx_FERROR(rx_ferror),
    .Rx_PERROR(rx_perror), .digits(dig_b), .frame_valid(fv_b), .frame_error(fe_b), .frame_timeout(ft_b));

  // C: six digits, three bytes per frame.
  uart_frame_decoder #(.NUM_DIGITS(6), .DIGIT_W(4), .BYTE_W(8), .BIT_REVERSE(1), .TIMEOUT_CYC(50000)) dut_c (
    .clk(clk), .reset(reset), .Rx_DATA(rx_data), .Rx_VALID(rx_valid), .Rx_FERROR(rx_ferror),
    .Rx_PERROR(rx_perror), .digits(dig_c), .frame_valid(fv_c), .frame_error(fe_c), .frame_timeout(ft_c));

  logic        m_v, m_e, m_t;
  logic [23:0] m_d;
  logic [1:0]  m_kind;
  exp_t        m_exp;

  // Monitor: score every pulse of the selected instance against the queue.
  always @(negedge clk) begin
    case (sel)
      0:       begin m_v = fv_a; m_e = fe_a; m_t = ft_a; m_d = {8'h00, dig_a}; end
      1:       begin m_v = fv_b; m_e = fe_b; m_t = ft_b; m_d = {8'h00, dig_b}; end
      default: begin m_v = fv_c; m_e = fe_c; m_t = ft_c; m_d = dig_c; end
    endcase
    if (reset && (m_v || m_e || m_t)) begin
      m_kind = m_v ? K_VALID : (m_e ? K_ERROR : K_TIMEOUT);
      total++;
      if ((int'(m_v) + int'(m_e) + int'(m_t)) != 1) begin
        bad++;
        $display("FAIL exclusive_pulses: got v=%0b e=%0b t=%0b want exactly one", m_v, m_e, m_t);
      end
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: got kind=%0d digits=%h want no pulse", m_kind, m_d);
      end else begin
        m_exp = exp_q.pop_front();
        if (m_kind !== m_exp.kind || m_d !== m_exp.dig) begin
          bad++;
          $display("FAIL scoreboard: got kind=%0d digits=%h want kind=%0d digits=%h",
                   m_kind, m_d, m_exp.kind, m_exp.dig);
        end
      end
    end
  end

  task automatic do_reset();
    reset     = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    rx_ferror = 1'b0;
    rx_perror = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Present one byte for a single clock edge; returns on the following negedge.
  task automatic send(input logic [7:0] b, input logic f, input logic p);
    rx_data   = b;
    rx_valid  = 1'b1;
    rx_ferror = f;
    rx_perror = p;
    @(negedge clk);
    rx_valid  = 1'b0;
    rx_ferror = 1'b0;
    rx_perror = 1'b0;
  endtask

  task automatic push(input logic [1:0] kind, input logic [23:0] dig);
    exp_q.push_back('{kind: kind, dig: dig});
  endtask

  // Everything expected so far must already have been seen (1-clock latency).
  task automatic check_drained(input string name);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: got %0d pulses still pending want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    sel = 0;
    reset = 1'b0;
    rx_valid = 1'b0; rx_ferror = 1'b0; rx_perror = 1'b0; rx_data = 8'h00;
    @(negedge clk);
    total++;
    if (dig_a !== 16'hBBBB || dig_b !== 16'hBBBB || dig_c !== 24'hBBBBBB) begin
      bad++;
      $display("FAIL reset_digits: got %h %h %h want bbbb bbbb bbbbbb", dig_a, dig_b, dig_c);
    end
    total++;
    if ({fv_a, fe_a, ft_a, fv_b, fe_b, ft_b, fv_c, fe_c, ft_c} !== 9'b0) begin
      bad++;
      $display("FAIL reset_pulses: got %b want 0", {fv_a, fe_a, ft_a, fv_b, fe_b, ft_b, fv_c, fe_c, ft_c});
    end
    reset = 1'b1;
    push(K_VALID, 24'h002C48);
    send(8'h12, 1'b0, 1'b0);
    send(8'h34, 1'b0, 1'b0);
    check_drained("reset_pre_frame");
    send(8'h12, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (dig_a !== 16'hBBBB || {fv_a, fe_a, ft_a} !== 3'b000) begin
      bad++;
      $display("FAIL reset_midframe: got digits=%h pulses=%b want bbbb 000", dig_a, {fv_a, fe_a, ft_a});
    end
    @(negedge clk);
    reset = 1'b1;
    push(K_VALID, 24'h002C48);
    send(8'h12, 1'b0, 1'b0);
    send(8'h34, 1'b0, 1'b0);
    check_drained("reset_discard_partial");
  endtask

  task automatic test_bit_reverse();
    sel = 0;
    do_reset();
    push(K_VALID, 24'h002C48);
    send(8'h12, 1'b0, 1'b0);
    total++;
    if (exp_q.size() != 1) begin
      bad++;
      $display("FAIL reverse_early: got %0d pending want 1", exp_q.size());
    end
    send(8'h34, 1'b0, 1'b0);
    check_drained("reverse_latency");
    total++;
    if (dig_a !== 16'h2C48) begin
      bad++;
      $display("FAIL reverse_digits: got %h want 2c48", dig_a);
    end
  endtask

  task automatic test_passthrough_error();
    sel = 1;
    do_reset();
    push(K_VALID, 24'h001234);
    send(8'h12, 1'b0, 1'b0);
    send(8'h34, 1'b0, 1'b0);
    check_drained("pass_frame");
    push(K_ERROR, 24'h00AAAA);
    send(8'hAB, 1'b0, 1'b1);
    check_drained("perror_pulse");
    @(negedge clk);
    total++;
    if (fe_b !== 1'b0 || dig_b !== 16'hAAAA) begin
      bad++;
      $display("FAIL error_hold: got fe=%b digits=%h want 0 aaaa", fe_b, dig_b);
    end
    send(8'h12, 1'b0, 1'b0);
    push(K_ERROR, 24'h00AAAA);
    send(8'h34, 1'b1, 1'b0);
    check_drained("ferror_midframe");
    push(K_VALID, 24'h005678);
    send(8'h56, 1'b0, 1'b0);
    send(8'h78, 1'b0, 1'b0);
    check_drained("after_error_frame");
  endtask

  task automatic test_timeout();
    sel = 0;
    do_reset();
    push(K_VALID, 24'h002C48);
    send(8'h12, 1'b0, 1'b0);
    send(8'h34, 1'b0, 1'b0);
    check_drained("timeout_setup");
    send(8'h12, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    push(K_TIMEOUT, 24'h002C48);
    @(negedge clk);
    check_drained("timeout_pulse");
    total++;
    if (dig_a !== 16'h2C48) begin
      bad++;
      $display("FAIL timeout_digits: got %h want 2c48", dig_a);
    end
    push(K_VALID, 24'h001E6A);
    send(8'h56, 1'b0, 1'b0);
    send(8'h78, 1'b0, 1'b0);
    check_drained("after_timeout_frame");
  endtask

  task automatic test_timeout_race();
    sel = 0;
    do_reset();
    send(8'h12, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    push(K_VALID, 24'h002C48);
    send(8'h34, 1'b0, 1'b0);
    check_drained("race_byte_wins");
    repeat (12) @(negedge clk);
    total++;
    if (dig_a !== 16'h2C48) begin
      bad++;
      $display("FAIL race_digits: got %h want 2c48", dig_a);
    end
  endtask

  task automatic test_six_digits();
    sel = 2;
    do_reset();
    send(8'h12, 1'b0, 1'b0);
    rx_ferror = 1'b1;
    rx_perror = 1'b1;
    @(negedge clk);
    rx_ferror = 1'b0;
    rx_perror = 1'b0;
    send(8'h34, 1'b0, 1'b0);
    push(K_VALID, 24'h6A2C48);
    send(8'h56, 1'b0, 1'b0);
    check_drained("six_digit_frame");
    total++;
    if (dig_c !== 24'h6A2C48) begin
      bad++;
      $display("FAIL six_digits: got %h want 6a2c48", dig_c);
    end
  endtask

  task automatic test_back_to_back();
    sel = 0;
    do_reset();
    push(K_VALID, 24'h002C48);
    push(K_VALID, 24'h001E6A);
    send(8'h12, 1'b0, 1'b0);
    send(8'h34, 1'b0, 1'b0);
    send(8'h56, 1'b0, 1'b0);
    send(8'h78, 1'b0, 1'b0);
    check_drained("back_to_back");
    total++;
    if (dig_a !== 16'h1E6A) begin
      bad++;
      $display("FAIL back_to_back_digits: got %h want 1e6a", dig_a);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    sel   = 0;
    reset = 1'b0;
    rx_data = 8'h00; rx_valid = 1'b0; rx_ferror = 1'b0; rx_perror = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_bit_reverse();
    test_passthrough_error();
    test_timeout();
    test_timeout_race();
    test_six_digits();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
